// File: rtl/adc_sample_front.sv
// ADC capture front end: source select (ADC/counter/pattern/LFSR), per-channel
// enable, downsampled valid generation and sticky clip monitoring.
module adc_sample_front #(
    parameter int pDATA_WIDTH = 12,
    parameter int pCHANNELS   = 2,
    parameter int pDS_WIDTH   = 13
) (
    input  logic                             adc_sampleclk,
    input  logic                             reset,
    input  logic [pCHANNELS*pDATA_WIDTH-1:0] adc_data_i,
    input  logic [1:0]                       source_sel,
    input  logic [pDATA_WIDTH-1:0]           pattern_i,
    input  logic [pCHANNELS-1:0]             channel_en,
    input  logic [pDS_WIDTH-1:0]             downsample_i,
    input  logic                             capture_go_i,
    input  logic                             clip_clear_i,
    output logic [pCHANNELS*pDATA_WIDTH-1:0] data_o,
    output logic                             data_valid_o,
    output logic [pCHANNELS-1:0]             clip_flags_o,
    output logic [15:0]                      clip_count_o
);

    localparam int W = pDATA_WIDTH;
    localparam int C = pCHANNELS;

    typedef enum logic [1:0] {
        SRC_ADC     = 2'd0,
        SRC_COUNTER = 2'd1,
        SRC_PATTERN = 2'd2,
        SRC_LFSR    = 2'd3
    } source_t;

    // Maximal-length feedback taps (bit index = tap-1); widths outside the
    // table fall back to a non-maximal two-tap sequence.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            default: m = 32'h0000_0003 << (w - 2);
        endcase
        return m;
    endfunction

    localparam logic [31:0] LFSR_TAPS = lfsr_taps(pDATA_WIDTH);

    // Stage 1 registers
    logic [C*W-1:0]       adc_reg;
    source_t              sel_reg;
    logic [W-1:0]         pattern_reg;
    logic [C-1:0]         en_reg;
    logic                 valid_reg;

    // Free-running sources and downsampler
    logic [W-1:0]         counter_reg;
    logic [W-1:0]         lfsr_reg;
    logic [W-1:0]         lfsr_next;
    logic [pDS_WIDTH-1:0] ds_cnt_reg;
    logic [pDS_WIDTH-1:0] ds_cnt_next;
    logic                 valid_next;

    // Stage 2 / status
    logic [C*W-1:0]       data_reg;
    logic [C*W-1:0]       data_next;
    logic                 data_valid_reg;
    logic [C-1:0]         clip_vec;
    logic [C-1:0]         flags_reg;
    logic [C-1:0]         flags_next;
    logic [15:0]          count_reg;
    logic [15:0]          count_next;

    assign lfsr_next = {lfsr_reg[W-2:0], ^(lfsr_reg & LFSR_TAPS[W-1:0])};

    // Comparing with >= lets a reduced downsample_i wrap immediately.
    always_comb begin
        ds_cnt_next = '0;
        valid_next  = 1'b0;
        if (capture_go_i) begin
            valid_next = (ds_cnt_reg == '0);
            if (ds_cnt_reg >= downsample_i) begin
                ds_cnt_next = '0;
            end else begin
                ds_cnt_next = ds_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C; gi++) begin : g_ch
            localparam logic [W-1:0] CH_IDX = W'(gi);
            logic [W-1:0] sample;
            logic [W-1:0] ch_next;

            assign sample = adc_reg[gi*W +: W];

            always_comb begin
                ch_next = '0;
                if (en_reg[gi]) begin
                    case (sel_reg)
                        SRC_ADC:     ch_next = sample;
                        SRC_COUNTER: ch_next = counter_reg + CH_IDX;
                        SRC_PATTERN: ch_next = pattern_reg;
                        SRC_LFSR:    ch_next = lfsr_reg ^ CH_IDX;
                        default:     ch_next = '0;
                    endcase
                end
            end

            assign data_next[gi*W +: W] = ch_next;
            assign clip_vec[gi] = (sel_reg == SRC_ADC) && en_reg[gi] &&
                                  ((&sample) || ~(|sample));
        end
    endgenerate

    // A clear coinciding with a clip keeps that cycle's clip recorded.
    always_comb begin
        flags_next = flags_reg | clip_vec;
        count_next = count_reg;
        if (clip_clear_i) begin
            flags_next = clip_vec;
            count_next = (|clip_vec) ? 16'd1 : 16'd0;
        end else if ((|clip_vec) && (count_reg != 16'hFFFF)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge adc_sampleclk) begin
        if (reset) begin
            adc_reg        <= '0;
            sel_reg        <= SRC_ADC;
            pattern_reg    <= '0;
            en_reg         <= '0;
            valid_reg      <= 1'b0;
            counter_reg    <= '0;
            lfsr_reg       <= '1;
            ds_cnt_reg     <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            flags_reg      <= '0;
            count_reg      <= '0;
        end else begin
            adc_reg        <= adc_data_i;
            sel_reg        <= source_t'(source_sel);
            pattern_reg    <= pattern_i;
            en_reg         <= channel_en;
            valid_reg      <= valid_next;
            counter_reg    <= counter_reg + 1'b1;
            lfsr_reg       <= lfsr_next;
            ds_cnt_reg     <= ds_cnt_next;
            data_reg       <= data_next;
            data_valid_reg <= valid_reg;
            flags_reg      <= flags_next;
            count_reg      <= count_next;
        end
    end

    assign data_o       = data_reg;
    assign data_valid_o = data_valid_reg;
    assign clip_flags_o = flags_reg;
    assign clip_count_o = count_reg;

endmodule

// File: tb/tb_adc_sample_front.sv
// Randomised scoreboard bench for adc_sample_front: a cycle-level reference
// model queues the expected output of every edge; a negedge monitor compares.
module tb_adc_sample_front;

    localparam int W   = 12;
    localparam int C   = 2;
    localparam int DSW = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic [C*W-1:0]   adc_data_i;
    logic [1:0]       source_sel;
    logic [W-1:0]     pattern_i;
    logic [C-1:0]     channel_en;
    logic [DSW-1:0]   downsample_i;
    logic             capture_go_i;
    logic             clip_clear_i;
    logic [C*W-1:0]   data_o;
    logic             data_valid_o;
    logic [C-1:0]     clip_flags_o;
    logic [15:0]      clip_count_o;

    always #5 clk = ~clk;

    adc_sample_front #(
        .pDATA_WIDTH(W),
        .pCHANNELS  (C),
        .pDS_WIDTH  (DSW)
    ) dut (
        .adc_sampleclk(clk),
        .reset        (reset),
        .adc_data_i   (adc_data_i),
        .source_sel   (source_sel),
        .pattern_i    (pattern_i),
        .channel_en   (channel_en),
        .downsample_i (downsample_i),
        .capture_go_i (capture_go_i),
        .clip_clear_i (clip_clear_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .clip_flags_o (clip_flags_o),
        .clip_count_o (clip_count_o)
    );

    typedef struct {
        int unsigned    edge_no;
        logic           valid;
        logic [C*W-1:0] data;
        logic [C-1:0]   flags;
        logic [15:0]    count;
    } exp_t;

    typedef struct {
        logic [C*W-1:0] adc;
        logic [1:0]     sel;
        logic [W-1:0]   pat;
        logic [C-1:0]   en;
        logic           vdec;
    } stage_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned abs_edge   = 0;
    int          compared   = 0;
    int          mismatched = 0;

    // Reference model state
    stage_t       prev;
    int           ds_m;
    int           rel;
    logic [C-1:0] flags_m;
    int           count_m;
    logic [W-1:0] lfsr_seq [0:4094];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s edge %0d: got %h required %h", name, abs_edge - 1, act, req);
        end
    endtask

    // Predict the output of the upcoming edge, then advance one clock.
    task automatic drive_cycle();
        exp_t         e;
        stage_t       cur;
        logic [C-1:0] clips;
        logic [W-1:0] s;
        logic [W-1:0] v;
        e.edge_no = abs_edge;
        if (reset) begin
            e.valid = 1'b0;
            e.data  = '0;
            e.flags = '0;
            e.count = '0;
            prev    = '{adc: '0, sel: 2'd0, pat: '0, en: '0, vdec: 1'b0};
            ds_m    = 0;
            rel     = 0;
            flags_m = '0;
            count_m = 0;
        end else begin
            clips = '0;
            for (int n = 0; n < C; n++) begin
                s = prev.adc[n*W +: W];
                v = '0;
                if (prev.en[n]) begin
                    case (prev.sel)
                        2'd0: v = s;
                        2'd1: v = W'((rel + n) % 4096);
                        2'd2: v = prev.pat;
                        default: v = lfsr_seq[rel % 4095] ^ W'(n);
                    endcase
                end
                e.data[n*W +: W] = v;
                if (prev.sel == 2'd0 && prev.en[n] && (s == '0 || s == {W{1'b1}}))
                    clips[n] = 1'b1;
            end
            if (clip_clear_i) begin
                flags_m = clips;
                count_m = (clips != '0) ? 1 : 0;
            end else begin
                flags_m = flags_m | clips;
                if (clips != '0 && count_m < 65535) count_m++;
            end
            e.valid = prev.vdec;
            e.flags = flags_m;
            e.count = 16'(count_m);
            cur.adc  = adc_data_i;
            cur.sel  = source_sel;
            cur.pat  = pattern_i;
            cur.en   = channel_en;
            cur.vdec = 1'b0;
            if (capture_go_i) begin
                cur.vdec = (ds_m == 0);
                ds_m     = (ds_m >= int'(downsample_i)) ? 0 : ds_m + 1;
            end else begin
                ds_m = 0;
            end
            prev = cur;
            rel++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        abs_edge++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) drive_cycle();
    endtask

    task automatic set_mode(input logic [1:0] sel, input logic [C-1:0] en,
                            input int down, input logic cap);
        source_sel   = sel;
        channel_en   = en;
        downsample_i = DSW'(down);
        capture_go_i = cap;
    endtask

    function automatic logic [W-1:0] rand_sample();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return W'($urandom);
    endfunction

    // Monitor: pop the record for the edge just taken and compare everything.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].edge_no + 1 < abs_edge) begin
            mon_e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL stale_record edge %0d: got unchecked required checked", mon_e.edge_no);
        end
        if (exp_q.size() > 0 && exp_q[0].edge_no + 1 == abs_edge) begin
            mon_e = exp_q.pop_front();
            check("valid", 64'(data_valid_o), 64'(mon_e.valid));
            check("data", 64'(data_o), 64'(mon_e.data));
            check("clip_flags", 64'(clip_flags_o), 64'(mon_e.flags));
            check("clip_count", 64'(clip_count_o), 64'(mon_e.count));
            if (data_valid_o)
                $display("txn edge %0d data %h flags %b count %0d",
                         mon_e.edge_no, data_o, clip_flags_o, clip_count_o);
        end
    end

    initial begin
        logic [W-1:0] st;
        st = '1;
        for (int k = 0; k < 4095; k++) begin
            lfsr_seq[k] = st;
            st = {st[W-2:0], st[11] ^ st[5] ^ st[3] ^ st[0]};
        end

        reset        = 1'b1;
        adc_data_i   = '0;
        pattern_i    = '0;
        clip_clear_i = 1'b0;
        set_mode(2'd0, 2'b00, 0, 1'b0);
        run(3);
        reset = 1'b0;

        // Counter source, valid every cycle, long enough to wrap 0xFFF
        set_mode(2'd1, 2'b11, 0, 1'b1);
        for (int i = 0; i < 4200; i++) begin
            adc_data_i = (C*W)'($urandom);
            drive_cycle();
        end

        // ADC source, keep 1 of 4 across a 16-cycle window
        set_mode(2'd0, 2'b11, 3, 1'b0);
        run(3);
        capture_go_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            adc_data_i = {W'($urandom_range(1, 4094)), W'($urandom_range(1, 4094))};
            drive_cycle();
        end
        capture_go_i = 1'b0;
        run(4);

        // Clip on both channels for three cycles, then clear
        clip_clear_i = 1'b1;
        drive_cycle();
        clip_clear_i = 1'b0;
        adc_data_i = {12'hFFF, 12'h000};
        run(3);
        adc_data_i = {12'h123, 12'h456};
        run(3);
        clip_clear_i = 1'b1;
        drive_cycle();
        clip_clear_i = 1'b0;
        run(2);

        // Pattern with channel 1 disabled; then a disabled channel at full scale
        set_mode(2'd2, 2'b01, 0, 1'b1);
        pattern_i = 12'hA5A;
        run(5);
        source_sel = 2'd0;
        adc_data_i = {12'hFFF, 12'h321};
        run(4);

        // Shrink downsample mid-run, then reset in the middle of capture
        set_mode(2'd0, 2'b11, 100, 1'b0);
        run(2);
        capture_go_i = 1'b1;
        run(50);
        downsample_i = DSW'(2);
        run(20);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(10);

        // Random mixture of everything
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) source_sel = 2'($urandom);
            if ($urandom_range(0, 19) == 0) channel_en = C'($urandom);
            if ($urandom_range(0, 29) == 0) downsample_i = DSW'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) capture_go_i = ($urandom_range(0, 3) != 0);
            pattern_i    = W'($urandom);
            clip_clear_i = ($urandom_range(0, 29) == 0);
            for (int n = 0; n < C; n++) adc_data_i[n*W +: W] = rand_sample();
            drive_cycle();
        end
        clip_clear_i = 1'b0;

        // Drive clip count into saturation, then clear together with a clip
        set_mode(2'd0, 2'b01, 0, 1'b0);
        adc_data_i   = {12'h555, 12'h000};
        clip_clear_i = 1'b1;
        drive_cycle();
        clip_clear_i = 1'b0;
        run(65540);
        clip_clear_i = 1'b1;
        drive_cycle();
        clip_clear_i = 1'b0;
        adc_data_i = {12'h555, 12'h444};
        run(3);

        @(negedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adc_sample_front.md
ADC_SAMPLE_FRONT -- requirements
Module: adc_sample_front

Interface
REQ-001 SHALL provide parameter pDATA_WIDTH, default 12, ADC sample width per channel.
REQ-002 SHALL provide parameter pCHANNELS, default 2, number of ADC channels.
REQ-003 SHALL provide parameter pDS_WIDTH, default 13, downsample counter width.
REQ-004 SHALL have port adc_sampleclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port adc_data_i  input  pCHANNELS*pDATA_WIDTH  raw ADC samples, channel n at bits [n*W +: W].
REQ-007 SHALL have port source_sel  input  2  0=ADC, 1=counter, 2=fixed pattern, 3=LFSR.
REQ-008 SHALL have port pattern_i  input  pDATA_WIDTH  fixed-pattern value.
REQ-009 SHALL have port channel_en  input  pCHANNELS  per-channel enable.
REQ-010 SHALL have port downsample_i  input  pDS_WIDTH  keep 1 of (downsample_i+1) samples.
REQ-011 SHALL have port capture_go_i  input  1  capture window; valid only while high.
REQ-012 SHALL have port clip_clear_i  input  1  single-cycle clear of clip status.
REQ-013 SHALL have port data_o  output  pCHANNELS*pDATA_WIDTH  conditioned samples.
REQ-014 SHALL have port data_valid_o  output  1  data_o qualifies for FIFO write.
REQ-015 SHALL have port clip_flags_o  output  pCHANNELS  sticky per-channel clip flags.
REQ-016 SHALL have port clip_count_o  output  16  saturating clip-cycle count.

Function
REQ-017 SHALL register adc_data_i, source_sel, pattern_i, channel_en once (stage 1), then produce data_o/data_valid_o from a second register (stage 2): latency 2 cycles input-to-output.
REQ-018 Counter mode SHALL output free-running W-bit counter plus channel index n (mod 2^W) per channel; counter increments every cycle, wraps 2^W-1 -> 0.
REQ-019 Pattern mode SHALL output stage-1 pattern_i on every channel.
REQ-020 LFSR mode SHALL output a W-bit maximal-length Fibonacci LFSR, seed all-ones, advancing every cycle; channel n gets LFSR XOR n; LFSR never reaches all-zeros.
REQ-021 Disabled channels SHALL output zero regardless of source.
REQ-022 Downsample counter ds_cnt SHALL be held at 0 while capture_go_i low.
REQ-023 While capture_go_i high: valid generated when ds_cnt==0; ds_cnt <- 0 if ds_cnt >= downsample_i, else ds_cnt+1.
REQ-024 downsample_i==0 SHALL yield valid every cycle while capture_go_i high.
REQ-025 Lowering downsample_i below current ds_cnt mid-run SHALL wrap ds_cnt to 0 next cycle (no 2^pDS_WIDTH stall).
REQ-026 data_valid_o SHALL follow the valid decision with the same 2-cycle alignment as data_o; data_o updates every cycle regardless of valid.
REQ-027 Clip SHALL be detected only in ADC mode, on enabled channels, when stage-1 sample is all-ones or all-zeros, irrespective of capture_go_i.
REQ-028 clip_flags_o[n] SHALL set on a channel-n clip and stay set until clip_clear_i.
REQ-029 clip_count_o SHALL increment by 1 per cycle with any clip (not per channel), saturating at 0xFFFF.
REQ-030 clip_clear_i with a simultaneous clip SHALL leave the new clip recorded: flags = that cycle's clips, count = 1.
REQ-031 source_sel change SHALL take effect on data_o exactly 2 cycles later with no invalid intermediate value.

Reset
REQ-032 reset SHALL set data_o=0, data_valid_o=0, clip_flags_o=0, clip_count_o=0, ds_cnt=0, counter=0, LFSR=all-ones, stage-1 registers=0.
REQ-033 reset mid-capture SHALL drop data_valid_o on the next edge and restart downsampling from ds_cnt=0 after release.

Verification
REQ-034 Counter mode, W=12, C=2, both enabled, downsample 0, capture_go high -> ch0 0,1,2..., ch1 = ch0+1, valid every cycle; 0xFFF wraps to 0x000.
REQ-035 ADC mode, downsample_i=3, capture_go high 16 cycles -> exactly 4 valids, spaced 4 cycles, first 2 cycles after capture_go rises.
REQ-036 ADC mode, ch1 driven 0xFFF for 3 cycles, ch0 0x000 the same cycles -> clip_flags_o=2'b11, clip_count_o=3; clip_clear_i pulse -> both 0.
REQ-037 clip_count at 0xFFFF plus further clips -> stays 0xFFFF; clip_clear_i coincident with a clip -> count 1.
REQ-038 channel_en=2'b01 in pattern mode, pattern_i=0xA5A -> ch0=0xA5A, ch1=0x000; ch1 at 0xFFF in ADC mode sets no flag.
REQ-039 downsample_i 100 -> 2 while ds_cnt=50 -> ds_cnt 0 next cycle, valid period 3 thereafter; reset asserted mid-run -> all outputs 0 next edge.
